vai_req_mux: RTL and testbench
==============================

# vai_req_mux

Parametrised N-way request multiplexer and response router sitting between the sub-AFU audit layer and the VAI manager upstream port. It arbitrates read requests from `NUM_SUB_AFUS` sub-AFUs round-robin and relocates each address by a per-AFU offset. It tags every request with the issuing AFU index in the upper mdata bits and routes responses back by that tag. It also tracks per-AFU outstanding requests, enforcing a cap and a drain-before-reset handshake that the fixed-count legacy mux lacks.

## Interface
- NUM_SUB_AFUS, 9, number of downstream sub-AFUs (2..64)
- ADDR_W, 42, request address width
- MDATA_W, 16, mdata width
- DATA_W, 512, response data width
- MAX_OUTSTANDING, 64, per-AFU in-flight cap (≥1)
- TAG_W, derived $clog2(NUM_SUB_AFUS), AFU tag width (local parameter)

Ports:
- pClk  in  1  clock; everything is on the rising edge
- SoftReset_n  in  1  reset; synchronous and active-low
- afu_req_valid  in  [N]  request valid per AFU
- afu_req_addr  in  [N][ADDR_W]  AFU-relative address
- afu_req_mdata  in  [N][MDATA_W]  AFU mdata
- afu_req_ready  out  [N]  request accepted this cycle (combinational)
- offset_array  in  [N][64]  per-AFU address offset; low ADDR_W bits used
- sub_afu_reset  in  [N]  per-AFU reset request from manager
- afu_drained  out  [N]  AFU quiesced (reset requested, zero outstanding)
- up_almFull  in  1  upstream backpressure
- up_req_valid  out  1  upstream request valid
- up_req_addr  out  ADDR_W  relocated address
- up_req_mdata  out  MDATA_W  tagged mdata
- up_rsp_valid  in  1  upstream response valid
- up_rsp_mdata  in  MDATA_W  response mdata (carries tag)
- up_rsp_data  in  DATA_W  response data
- afu_rsp_valid  out  [N]  one-hot response valid
- afu_rsp_mdata  out  MDATA_W  response mdata, tag bits cleared (shared)
- afu_rsp_data  out  DATA_W  response data (shared)
- err_tag  out  1  sticky: response with tag ≥ N
- err_underflow  out  1  sticky: response to AFU with zero outstanding

## Operation
- Eligibility of AFU i: afu_req_valid[i] & !sub_afu_reset[i] & cnt[i] < MAX_OUTSTANDING & !up_almFull.
- Round-robin arbitration: search starts at pointer `rr`. The first eligible AFU i gets afu_req_ready[i]=1, and at most one ready is asserted per cycle. On a grant, `rr` ← (i+1) mod N; with no grant, `rr` holds.
- Relocation: up_req_addr = afu_req_addr[i] + offset_array[i][ADDR_W-1:0], truncated mod 2^ADDR_W.
- Tagging: up_req_mdata[MDATA_W-1 -: TAG_W] = i; the low bits pass through. Any AFU-supplied upper bits are overwritten.
- Response routing: tag t = up_rsp_mdata upper TAG_W bits.
  - If t < N: afu_rsp_valid[t]=1 and afu_rsp_mdata has the tag bits zeroed.
  - If t ≥ N: the response is dropped and err_tag is set.
- Outstanding counters: cnt[i] is $clog2(MAX_OUTSTANDING+1) bits.
  - +1 on grant, −1 on response to i; a simultaneous grant and response leaves it unchanged.
  - A response to i with cnt[i]=0 is still delivered, cnt stays 0, and err_underflow is set.
- Drain: while sub_afu_reset[i] is high, AFU i is never granted. afu_drained[i] = sub_afu_reset[i] & (cnt[i]==0), registered. Deasserting sub_afu_reset[i] clears afu_drained[i] on the next edge.

## Timing
- Request path: grant in cycle t gives up_req_* valid in cycle t+1 (one register stage). up_req_valid is a single-cycle pulse per grant.
- up_almFull is sampled in the grant cycle; a request already registered still issues.
- Response path: up_rsp in cycle t gives afu_rsp_* in cycle t+1. Counter decrement takes effect at the edge ending cycle t.
- afu_drained rises one cycle after the counter reaches zero with reset held.
- Reset (SoftReset_n=0 at an edge) clears rr, all cnt, up_req_valid, afu_rsp_valid, afu_drained, err_tag and err_underflow. up_req_addr, up_req_mdata, afu_rsp_mdata and afu_rsp_data go to 0.
- Reset mid-operation discards in-flight state; responses arriving after reset to AFUs with cnt=0 set err_underflow.

## Test plan
- N=9, all AFUs valid continuously, almFull=0 → grants 0,1,…,8,0,… one per cycle; up_req_mdata tag matches the sequence at t+1.
- AFU 3 addr 0x100 with offset_array[3]=0x4000; AFU 8 addr 0x3FF_FFFF_FFFF with offset 2 → up_req_addr 0x4100 and 0x1 (wrap).
- MAX_OUTSTANDING=4, AFU 2 only, no responses → exactly 4 grants, then ready stays 0; one response with tag 2 → one further grant.
- AFU 5 has 3 outstanding, sub_afu_reset[5]=1 → no grants to 5. Three tag-5 responses → afu_drained[5]=1 the cycle after the third. Deassert reset → drained=0 next cycle.
- Response with tag 12 (N=9) → no afu_rsp_valid and err_tag=1 until reset. Response tag 0 with cnt[0]=0 → afu_rsp_valid[0]=1 and err_underflow=1.
- Same-cycle grant to AFU 1 and tag-1 response with cnt[1]=2 → cnt[1] stays 2. SoftReset_n=0 mid-burst → all outputs 0 at the next edge and rr restarts at 0.

Source files
------------

// File: rtl/vai_req_mux.sv
// ============================================================================
// vai_req_mux : round-robin VAI request mux with address relocation,
//               tag-based response routing and per-AFU outstanding tracking
// Rev 1.0
// ============================================================================
`default_nettype none

module vai_req_mux #(
  parameter int NUM_SUB_AFUS    = 9,
  parameter int ADDR_W          = 42,
  parameter int MDATA_W         = 16,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                                   pClk,
  input  logic                                   SoftReset_n,
  input  logic [NUM_SUB_AFUS-1:0]                afu_req_valid,
  input  logic [NUM_SUB_AFUS-1:0][ADDR_W-1:0]    afu_req_addr,
  input  logic [NUM_SUB_AFUS-1:0][MDATA_W-1:0]   afu_req_mdata,
  output logic [NUM_SUB_AFUS-1:0]                afu_req_ready,
  input  logic [NUM_SUB_AFUS-1:0][63:0]          offset_array,
  input  logic [NUM_SUB_AFUS-1:0]                sub_afu_reset,
  output logic [NUM_SUB_AFUS-1:0]                afu_drained,
  input  logic                                   up_almFull,
  output logic                                   up_req_valid,
  output logic [ADDR_W-1:0]                      up_req_addr,
  output logic [MDATA_W-1:0]                     up_req_mdata,
  input  logic                                   up_rsp_valid,
  input  logic [MDATA_W-1:0]                     up_rsp_mdata,
  input  logic [DATA_W-1:0]                      up_rsp_data,
  output logic [NUM_SUB_AFUS-1:0]                afu_rsp_valid,
  output logic [MDATA_W-1:0]                     afu_rsp_mdata,
  output logic [DATA_W-1:0]                      afu_rsp_data,
  output logic                                   err_tag,
  output logic                                   err_underflow
);

  localparam int TAG_W = $clog2(NUM_SUB_AFUS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int LOW_W = MDATA_W - TAG_W;

  logic [CNT_W-1:0]        cnt [NUM_SUB_AFUS];
  logic [NUM_SUB_AFUS-1:0] eligible;
  logic [NUM_SUB_AFUS-1:0] underflow_hit;
  logic [NUM_SUB_AFUS-1:0] rsp_onehot;
  logic [NUM_SUB_AFUS-1:0] unused_bits;

  logic [TAG_W-1:0]   rr;
  logic [TAG_W-1:0]   rr_next;
  logic [TAG_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [TAG_W:0]     cand;
  logic [ADDR_W-1:0]  reloc_addr;
  logic [MDATA_W-1:0] tagged_mdata;
  logic [TAG_W-1:0]   rsp_tag;
  logic               rsp_tag_ok;
  logic               rsp_hit;

  always_comb begin
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      eligible[i] = afu_req_valid[i] & ~sub_afu_reset[i] & ~up_almFull &
                    (cnt[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Walk the AFUs starting at rr, wrapping modulo N; first eligible wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SUB_AFUS; k++) begin
      cand = {1'b0, rr} + (TAG_W+1)'(k);
      if (cand >= (TAG_W+1)'(NUM_SUB_AFUS)) begin
        cand = cand - (TAG_W+1)'(NUM_SUB_AFUS);
      end
      if (!grant_vld && eligible[cand[TAG_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[TAG_W-1:0];
      end
    end
  end

  always_comb begin
    afu_req_ready = '0;
    if (grant_vld) begin
      afu_req_ready[grant_idx] = 1'b1;
    end
  end

  assign rr_next    = (grant_idx == TAG_W'(NUM_SUB_AFUS - 1)) ? '0 : grant_idx + TAG_W'(1);
  assign reloc_addr = afu_req_addr[grant_idx] + offset_array[grant_idx][ADDR_W-1:0];

  always_comb begin
    tagged_mdata                      = afu_req_mdata[grant_idx];
    tagged_mdata[MDATA_W-1 -: TAG_W]  = grant_idx;
  end

  assign rsp_tag    = up_rsp_mdata[MDATA_W-1 -: TAG_W];
  assign rsp_tag_ok = ({1'b0, rsp_tag} < (TAG_W+1)'(NUM_SUB_AFUS));
  assign rsp_hit    = up_rsp_valid & rsp_tag_ok;

  always_comb begin
    rsp_onehot = '0;
    if (rsp_hit) begin
      rsp_onehot[rsp_tag] = 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < NUM_SUB_AFUS; i++) begin : g_afu
      logic inc;
      logic dec;

      assign inc              = grant_vld & (grant_idx == TAG_W'(i));
      assign dec              = rsp_hit & (rsp_tag == TAG_W'(i));
      assign underflow_hit[i] = dec & (cnt[i] == '0);

      // A grant and a response in the same cycle cancel out.
      always_ff @(posedge pClk) begin
        if (!SoftReset_n) begin
          cnt[i]         <= '0;
          afu_drained[i] <= 1'b0;
        end else begin
          if (inc && !dec) begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end else if (dec && !inc && (cnt[i] != '0)) begin
            cnt[i] <= cnt[i] - CNT_W'(1);
          end
          afu_drained[i] <= sub_afu_reset[i] & (cnt[i] == '0);
        end
      end

      // Tag bits of the AFU mdata and offset bits above ADDR_W are ignored.
      if (ADDR_W < 64) begin : g_off_hi
        assign unused_bits[i] = (^afu_req_mdata[i][MDATA_W-1 -: TAG_W]) ^
                                (^offset_array[i][63:ADDR_W]);
      end else begin : g_off_full
        assign unused_bits[i] = ^afu_req_mdata[i][MDATA_W-1 -: TAG_W];
      end
    end
  endgenerate

  logic unused_reduce;
  assign unused_reduce = ^unused_bits;

  always_ff @(posedge pClk) begin
    if (!SoftReset_n) begin
      rr            <= '0;
      up_req_valid  <= 1'b0;
      up_req_addr   <= '0;
      up_req_mdata  <= '0;
      afu_rsp_valid <= '0;
      afu_rsp_mdata <= '0;
      afu_rsp_data  <= '0;
      err_tag       <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      up_req_valid <= grant_vld;
      if (grant_vld) begin
        rr           <= rr_next;
        up_req_addr  <= reloc_addr;
        up_req_mdata <= tagged_mdata;
      end
      afu_rsp_valid <= rsp_onehot;
      if (rsp_hit) begin
        afu_rsp_mdata <= {{TAG_W{1'b0}}, up_rsp_mdata[LOW_W-1:0]};
        afu_rsp_data  <= up_rsp_data;
      end
      if (up_rsp_valid && !rsp_tag_ok) begin
        err_tag <= 1'b1;
      end
      if (|underflow_hit) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vai_req_mux.sv
// ============================================================================
// tb_vai_req_mux : directed + randomized bench for vai_req_mux against a
//                  cycle-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vai_req_mux;

  localparam int N       = 9;
  localparam int ADDR_W  = 42;
  localparam int MDATA_W = 16;
  localparam int DATA_W  = 64;
  localparam int MAX_OUT = 4;
  localparam int TAG_W   = 4;
  localparam int LOW_W   = MDATA_W - TAG_W;
  localparam int LOW_MOD = 1 << LOW_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst_n;
  logic [N-1:0]                 req_valid;
  logic [N-1:0][ADDR_W-1:0]     req_addr;
  logic [N-1:0][MDATA_W-1:0]    req_mdata;
  logic [N-1:0]                 afu_req_ready;
  logic [N-1:0][63:0]           offset;
  logic [N-1:0]                 sub_rst;
  logic [N-1:0]                 afu_drained;
  logic                         alm;
  logic                         up_req_valid;
  logic [ADDR_W-1:0]            up_req_addr;
  logic [MDATA_W-1:0]           up_req_mdata;
  logic                         rsp_valid;
  logic [MDATA_W-1:0]           rsp_mdata;
  logic [DATA_W-1:0]            rsp_data;
  logic [N-1:0]                 afu_rsp_valid;
  logic [MDATA_W-1:0]           afu_rsp_mdata;
  logic [DATA_W-1:0]            afu_rsp_data;
  logic                         err_tag;
  logic                         err_underflow;

  vai_req_mux #(
    .NUM_SUB_AFUS(N), .ADDR_W(ADDR_W), .MDATA_W(MDATA_W),
    .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .pClk(clk), .SoftReset_n(rst_n),
    .afu_req_valid(req_valid), .afu_req_addr(req_addr), .afu_req_mdata(req_mdata),
    .afu_req_ready(afu_req_ready), .offset_array(offset), .sub_afu_reset(sub_rst),
    .afu_drained(afu_drained), .up_almFull(alm),
    .up_req_valid(up_req_valid), .up_req_addr(up_req_addr), .up_req_mdata(up_req_mdata),
    .up_rsp_valid(rsp_valid), .up_rsp_mdata(rsp_mdata), .up_rsp_data(rsp_data),
    .afu_rsp_valid(afu_rsp_valid), .afu_rsp_mdata(afu_rsp_mdata), .afu_rsp_data(afu_rsp_data),
    .err_tag(err_tag), .err_underflow(err_underflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int              m_rr;
  int              m_cnt [N];
  bit              m_err_tag;
  bit              m_err_uf;
  bit [N-1:0]      m_drained;
  bit              e_reset;
  bit              e_up_valid;
  logic [ADDR_W-1:0]  e_up_addr;
  logic [MDATA_W-1:0] e_up_mdata;
  bit [N-1:0]      e_rsp_valid;
  logic [MDATA_W-1:0] e_rsp_mdata;
  logic [DATA_W-1:0]  e_rsp_data;
  logic [N-1:0]    last_ready;

  // One clock cycle: inputs are already driven; predict, clock, compare.
  task automatic step();
    int g;
    int t;
    logic [N-1:0] exp_ready;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (g < 0 && req_valid[i] && !sub_rst[i] && m_cnt[i] < MAX_OUT && !alm) g = i;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    last_ready = afu_req_ready;
    if (rst_n) check_eq("ready", afu_req_ready, exp_ready);

    if (!rst_n) begin
      m_rr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_err_tag = 0; m_err_uf = 0; m_drained = '0;
      e_reset = 1; e_up_valid = 0; e_rsp_valid = '0;
    end else begin
      e_reset    = 0;
      e_up_valid = (g >= 0);
      if (g >= 0) begin
        e_up_addr  = ADDR_W'(64'(req_addr[g]) + offset[g]);
        e_up_mdata = MDATA_W'(g * LOW_MOD + int'(req_mdata[g]) % LOW_MOD);
      end
      t = int'(rsp_mdata) / LOW_MOD;
      e_rsp_valid = '0;
      if (rsp_valid) begin
        if (t < N) begin
          e_rsp_valid[t] = 1'b1;
          e_rsp_mdata    = MDATA_W'(int'(rsp_mdata) % LOW_MOD);
          e_rsp_data     = rsp_data;
        end else begin
          m_err_tag = 1;
        end
      end
      for (int i = 0; i < N; i++) begin
        bit inc;
        bit dec;
        m_drained[i] = sub_rst[i] && (m_cnt[i] == 0);
        inc = (g == i);
        dec = rsp_valid && (t < N) && (t == i);
        if (dec && m_cnt[i] == 0) m_err_uf = 1;
        if (inc && !dec) m_cnt[i]++;
        else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
      end
      if (g >= 0) m_rr = (g + 1) % N;
    end

    @(posedge clk);
    @(negedge clk);
    check_eq("up_req_valid", up_req_valid, e_up_valid);
    check_eq("afu_rsp_valid", afu_rsp_valid, e_rsp_valid);
    check_eq("afu_drained", afu_drained, m_drained);
    check_eq("err_tag", err_tag, m_err_tag);
    check_eq("err_underflow", err_underflow, m_err_uf);
    if (e_up_valid) begin
      check_eq("up_req_addr", up_req_addr, e_up_addr);
      check_eq("up_req_mdata", up_req_mdata, e_up_mdata);
    end
    if (e_rsp_valid != '0) begin
      check_eq("afu_rsp_mdata", afu_rsp_mdata, e_rsp_mdata);
      check_eq("afu_rsp_data", afu_rsp_data, e_rsp_data);
    end
    if (e_reset) begin
      check_eq("rst_up_addr", up_req_addr, 0);
      check_eq("rst_up_mdata", up_req_mdata, 0);
      check_eq("rst_rsp_mdata", afu_rsp_mdata, 0);
      check_eq("rst_rsp_data", afu_rsp_data, 0);
    end
    rsp_valid = 1'b0;
  endtask

  task automatic idle();
    req_valid = '0;
    sub_rst   = '0;
    alm       = 1'b0;
    rsp_valid = 1'b0;
  endtask

  task automatic send_rsp(input int tag);
    rsp_valid = 1'b1;
    rsp_mdata = MDATA_W'(tag * LOW_MOD + int'($urandom_range(0, LOW_MOD - 1)));
    rsp_data  = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = ADDR_W'({$urandom, $urandom});
      req_mdata[i] = MDATA_W'($urandom);
      offset[i]    = {$urandom, $urandom};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    rsp_mdata = '0;
    rsp_data  = '0;
    idle();
    randomize_payload();
    @(negedge clk);
    step();
    step();
    check_eq("reset_up_valid", up_req_valid, 0);
    check_eq("reset_rsp_valid", afu_rsp_valid, 0);
    check_eq("reset_drained", afu_drained, 0);
    check_eq("reset_errs", {err_tag, err_underflow}, 0);
    rst_n = 1'b1;

    // Round robin with every AFU requesting
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      step();
      check_eq("rr_tag", up_req_mdata >> LOW_W, k % N);
    end

    // Relocation, including address wrap
    do_reset();
    req_valid[3] = 1'b1; req_addr[3] = 42'h100; offset[3] = 64'h4000;
    step();
    check_eq("reloc_afu3", up_req_addr, 42'h4100);
    idle();
    req_valid[8] = 1'b1; req_addr[8] = 42'h3FF_FFFF_FFFF; offset[8] = 64'd2;
    step();
    check_eq("reloc_afu8_wrap", up_req_addr, 1);

    // Outstanding cap
    do_reset();
    req_valid[2] = 1'b1;
    n = 0;
    repeat (8) begin step(); n += int'(last_ready[2]); end
    check_eq("cap_grants", n, MAX_OUT);
    send_rsp(2);
    n = 0;
    repeat (5) begin step(); n += int'(last_ready[2]); end
    check_eq("cap_regrant", n, 1);

    // Drain handshake
    do_reset();
    req_valid[5] = 1'b1;
    repeat (3) step();
    sub_rst[5] = 1'b1;
    n = 0;
    repeat (3) begin step(); n += int'(last_ready[5]); end
    check_eq("drain_nogrant", n, 0);
    for (int j = 0; j < 3; j++) begin send_rsp(5); step(); end
    check_eq("drain_early", afu_drained[5], 0);
    step();
    check_eq("drain_set", afu_drained[5], 1);
    sub_rst[5] = 1'b0; req_valid[5] = 1'b0;
    step();
    check_eq("drain_clear", afu_drained[5], 0);

    // Bad tag and underflow
    do_reset();
    send_rsp(12);
    step();
    check_eq("badtag_rsp", afu_rsp_valid, 0);
    check_eq("badtag_err", err_tag, 1);
    send_rsp(0);
    step();
    check_eq("uf_rsp", afu_rsp_valid, 1);
    check_eq("uf_err", err_underflow, 1);
    step();
    check_eq("badtag_sticky", err_tag, 1);

    // Simultaneous grant and response
    do_reset();
    req_valid[1] = 1'b1;
    step(); step();
    send_rsp(1);
    step();
    check_eq("simul_grant", last_ready[1], 1);
    n = 0;
    repeat (5) begin step(); n += int'(last_ready[1]); end
    check_eq("simul_remaining", n, 2);

    // Reset mid-burst
    do_reset();
    req_valid = '1;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    check_eq("midrst_up_valid", up_req_valid, 0);
    check_eq("midrst_rsp_valid", afu_rsp_valid, 0);
    rst_n = 1'b1;
    step();
    check_eq("midrst_rr0", last_ready, 1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      randomize_payload();
      req_valid = N'($urandom);
      sub_rst   = sub_rst ^ N'($urandom & $urandom & $urandom & $urandom);
      alm       = ($urandom_range(0, 7) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 9) == 0) begin
          send_rsp(int'($urandom_range(0, 15)));
        end else begin
          int s;
          int pick;
          s = int'($urandom_range(0, N - 1));
          pick = s;
          for (int k = 0; k < N; k++) begin
            if (m_cnt[(s + k) % N] > 0) begin pick = (s + k) % N; break; end
          end
          send_rsp(pick);
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
